// File: rtl/isp_ref_frame_reader.sv
// Reference frame reader: fetches N RGB888 pixels from frame-buffer memory
// into a credit-limited FIFO and streams them to the temporal filter.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i                  begin a frame (accepted only when idle)
//   cfg_base_addr_i          first pixel address, sampled on accepted start
//   cfg_num_pixels_i         pixel count N, sampled on accepted start
//   busy_o, done_o           frame in progress / one-cycle end-of-frame pulse
//   mem_req_o, mem_addr_o    read request and address
//   mem_gnt_i                request accepted
//   mem_rvalid_i, mem_rdata_i in-order read responses {R,G,B}
//   pix_data_o, pix_valid_o  reference pixel stream
//   pix_ready_i, pix_last_o  consumer ready / final pixel of frame
module isp_ref_frame_reader #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_i,
    input  logic [ADDR_WIDTH-1:0] cfg_num_pixels_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [23:0]           mem_rdata_i,
    output logic [23:0]           pix_data_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  pix_last_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int NW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NW-1:0]         r_num;
    logic [NW-1:0]         r_issued;
    logic [NW-1:0]         r_outst;
    logic [NW-1:0]         r_deliv;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [23:0]           r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_done;

    logic          w_start;
    logic          w_zero_start;
    logic [NW:0]   w_used;
    logic          w_credit;
    logic          w_req;
    logic          w_gnt;
    logic          w_push;
    logic          w_valid;
    logic          w_pop;
    logic [NW-1:0] w_num_m1;
    logic          w_last_gnt;
    logic          w_last_pop;

    assign w_start      = start_i && (r_state == S_IDLE);
    assign w_zero_start = w_start && (cfg_num_pixels_i == '0);

    // Credits cover both in-flight reads and buffered pixels, so every
    // response is guaranteed a FIFO slot and the FIFO can never overflow.
    assign w_used   = {1'b0, r_outst} + (NW+1)'(r_count);
    assign w_credit = w_used < (NW+1)'(FIFO_DEPTH);
    assign w_req    = (r_state == S_FETCH) && w_credit;
    assign w_gnt    = w_req && mem_gnt_i;
    assign w_push   = mem_rvalid_i && (r_state != S_IDLE);
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && pix_ready_i;

    assign w_num_m1   = r_num - NW'(1);
    assign w_last_gnt = w_gnt && (r_issued == w_num_m1);
    assign w_last_pop = w_pop && (r_deliv == w_num_m1);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start && !w_zero_start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_last_gnt) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_pop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_num    <= '0;
            r_issued <= '0;
            r_outst  <= '0;
            r_deliv  <= '0;
            r_addr   <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_zero_start || w_last_pop;

            if (w_start) begin
                r_num    <= {1'b0, cfg_num_pixels_i};
                r_addr   <= cfg_base_addr_i;
                r_issued <= '0;
                r_deliv  <= '0;
            end else if (w_gnt) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_issued <= r_issued + NW'(1);
            end

            case ({w_gnt, w_push})
                2'b10:   r_outst <= r_outst + NW'(1);
                2'b01:   r_outst <= r_outst - NW'(1);
                default: r_outst <= r_outst;
            endcase

            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + PW'(1);
                r_deliv <= r_deliv + NW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is gated by r_count below.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= mem_rdata_i;
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign mem_req_o   = w_req;
    assign mem_addr_o  = r_addr;
    assign pix_valid_o = w_valid;
    assign pix_data_o  = w_valid ? r_mem[r_rptr] : 24'd0;
    assign pix_last_o  = w_valid && (r_deliv == w_num_m1);

endmodule
